// File: rtl/tms_sdm_pkg.sv
// Shared encodings and sizing helpers for the TMS sigma-delta decimator.
package tms_sdm_pkg;

    localparam logic MODE_STREAM  = 1'b0;
    localparam logic MODE_CHANNEL = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_e;

    // Largest window exponent whose full-window count (or channel sum) still fits cnt_width bits.
    function automatic logic [4:0] clamp_wlog2(input logic [4:0] w, input logic mode,
                                               input int cnt_width, input int nstream_log2);
        int lim;
        if (mode == MODE_CHANNEL) begin
            lim = cnt_width - 1 - nstream_log2;
        end else begin
            lim = cnt_width - 1;
        end
        if (int'(w) > lim) begin
            return 5'(lim);
        end else begin
            return w;
        end
    endfunction

    function automatic int nwords(input logic mode, input int nch, input int nstream);
        if (mode == MODE_CHANNEL) begin
            return nch;
        end else begin
            return nch * nstream;
        end
    endfunction

endpackage

// File: rtl/tms_sdm_decim_if.sv
// Valid/ready word stream from the decimator toward the readout FIFO.
interface tms_sdm_decim_if #(
    parameter int CNT_WIDTH = 16,
    parameter int IDX_WIDTH = 8
);
    logic [CNT_WIDTH-1:0] DOUT;
    logic [IDX_WIDTH-1:0] DOUT_IDX;
    logic                 DOUT_LAST;
    logic                 DOUT_VALID;
    logic                 DOUT_READY;

    modport master (output DOUT, DOUT_IDX, DOUT_LAST, DOUT_VALID, input DOUT_READY);
    modport slave  (input DOUT, DOUT_IDX, DOUT_LAST, DOUT_VALID, output DOUT_READY);
endinterface

// File: rtl/tms_sdm_word_ser.sv
// Shadow bank of frozen window counts plus the valid/ready word serializer.
module tms_sdm_word_ser
    import tms_sdm_pkg::*;
#(
    parameter int NCH       = 19,
    parameter int NSTREAM   = 2,
    parameter int CNT_WIDTH = 16,
    parameter int IDX_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 load,
    input  logic                 mode_in,
    input  logic [CNT_WIDTH-1:0] cnt_in [NCH*NSTREAM],
    input  logic                 clr_overrun,
    tms_sdm_decim_if.master      m,
    output logic                 overrun,
    output logic [15:0]          frame_cnt
);
    localparam int NS = NCH * NSTREAM;

    ser_state_e           state, state_nx;
    logic [IDX_WIDTH-1:0] idx, idx_nx;
    logic                 frame_mode, mode_nx;
    logic                 take, done, drop, hs, at_last, last_nx;
    logic [CNT_WIDTH-1:0] shadow [NS];
    logic [CNT_WIDTH-1:0] dout_nx;

    // Next state; a load arriving with the final handshake starts the next frame seamlessly
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        mode_nx  = frame_mode;
        take     = 1'b0;
        done     = 1'b0;
        drop     = 1'b0;
        hs       = m.DOUT_VALID & m.DOUT_READY;
        at_last  = (int'(idx) == nwords(frame_mode, NCH, NSTREAM) - 1);
        case (state)
            ST_IDLE: begin
                if (load) begin
                    state_nx = ST_SEND;
                    idx_nx   = '0;
                    mode_nx  = mode_in;
                    take     = 1'b1;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (hs && at_last) begin
                    done   = 1'b1;
                    idx_nx = '0;
                    if (load) begin
                        state_nx = ST_SEND;
                        mode_nx  = mode_in;
                        take     = 1'b1;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end else begin
                    drop = load;
                    if (hs) begin
                        idx_nx = idx + IDX_WIDTH'(1);
                    end else begin
                        idx_nx = idx;
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
                idx_nx   = '0;
            end
        endcase
        last_nx = (state_nx == ST_SEND) && (int'(idx_nx) == nwords(mode_nx, NCH, NSTREAM) - 1);
    end

    // Word for the next cycle: fresh snapshot on load, otherwise the held shadow entry
    always_comb begin
        dout_nx = '0;
        for (int k = 0; k < NS; k++) begin
            dout_nx = ((state_nx == ST_SEND) && (idx_nx == IDX_WIDTH'(k)))
                    ? (take ? cnt_in[k] : shadow[k]) : dout_nx;
        end
    end

    // State, shadow bank, status and registered stream outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= ST_IDLE;
            idx          <= '0;
            frame_mode   <= MODE_STREAM;
            shadow       <= '{default: '0};
            overrun      <= 1'b0;
            frame_cnt    <= 16'd0;
            m.DOUT       <= '0;
            m.DOUT_IDX   <= '0;
            m.DOUT_LAST  <= 1'b0;
            m.DOUT_VALID <= 1'b0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            frame_mode <= mode_nx;
            if (take) begin
                shadow <= cnt_in;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
            if (done) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            m.DOUT       <= dout_nx;
            m.DOUT_IDX   <= (state_nx == ST_SEND) ? idx_nx : '0;
            m.DOUT_LAST  <= last_nx;
            m.DOUT_VALID <= (state_nx == ST_SEND);
        end
    end

endmodule

// File: rtl/tms_sdm_decim.sv
// Decimating ones-counter for SDM bitstreams: per-stream accumulators, window control
// and hand-off of each completed window to the word serializer.
module tms_sdm_decim
    import tms_sdm_pkg::*;
#(
    parameter int NCH       = 19,
    parameter int NSTREAM   = 2,
    parameter int CNT_WIDTH = 16,
    parameter int IDX_WIDTH = 8
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [NCH*NSTREAM-1:0]   DIN,
    input  logic                     DIN_VALID,
    input  logic                     ENABLE,
    input  logic                     MODE,
    input  logic [4:0]               WINDOW_LOG2,
    input  logic                     CLR_OVERRUN,
    tms_sdm_decim_if.master          dout_bus,
    output logic                     OVERRUN,
    output logic [15:0]              FRAME_CNT
);
    localparam int NS           = NCH * NSTREAM;
    localparam int NSTREAM_LOG2 = $clog2(NSTREAM);

    logic                 enable_q, en_rise, boundary;
    logic                 cfg_mode, win_mode;
    logic [4:0]           cfg_wlog2, win_wlog2;
    logic [CNT_WIDTH-1:0] sample_cnt;
    logic [CNT_WIDTH-1:0] acc        [NS];
    logic [CNT_WIDTH-1:0] stream_sum [NS];
    logic [CNT_WIDTH-1:0] chan_sum   [NS];
    logic [CNT_WIDTH-1:0] word_vec   [NS];

    // Window geometry: the enabling cycle uses live settings, later windows the latched ones
    always_comb begin
        en_rise = ENABLE & ~enable_q;
        if (en_rise) begin
            win_mode  = MODE;
            win_wlog2 = clamp_wlog2(WINDOW_LOG2, MODE, CNT_WIDTH, NSTREAM_LOG2);
        end else begin
            win_mode  = cfg_mode;
            win_wlog2 = cfg_wlog2;
        end
        boundary = ENABLE & DIN_VALID
                 & (sample_cnt == ((CNT_WIDTH'(1) << win_wlog2) - CNT_WIDTH'(1)));
    end

    // Snapshot words including the current sample; channel sums only exist here
    always_comb begin
        for (int k = 0; k < NS; k++) begin
            stream_sum[k] = acc[k] + CNT_WIDTH'(DIN[k]);
            chan_sum[k]   = '0;
        end
        for (int c = 0; c < NCH; c++) begin
            for (int j = 0; j < NSTREAM; j++) begin
                chan_sum[c] = chan_sum[c] + stream_sum[c*NSTREAM + j];
            end
        end
        for (int k = 0; k < NS; k++) begin
            word_vec[k] = (win_mode == MODE_CHANNEL) ? chan_sum[k] : stream_sum[k];
        end
    end

    // Accumulators, sample counter and configuration latch
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            enable_q   <= 1'b0;
            cfg_mode   <= MODE_STREAM;
            cfg_wlog2  <= 5'd0;
            sample_cnt <= '0;
            acc        <= '{default: '0};
        end else begin
            enable_q <= ENABLE;
            if (en_rise || boundary) begin
                cfg_mode  <= MODE;
                cfg_wlog2 <= clamp_wlog2(WINDOW_LOG2, MODE, CNT_WIDTH, NSTREAM_LOG2);
            end
            if (!ENABLE || boundary) begin
                sample_cnt <= '0;
                acc        <= '{default: '0};
            end else if (DIN_VALID) begin
                sample_cnt <= sample_cnt + CNT_WIDTH'(1);
                for (int k = 0; k < NS; k++) begin
                    acc[k] <= stream_sum[k];
                end
            end
        end
    end

    tms_sdm_word_ser #(
        .NCH       (NCH),
        .NSTREAM   (NSTREAM),
        .CNT_WIDTH (CNT_WIDTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_ser (
        .CLK         (CLK),
        .RESET       (RESET),
        .load        (boundary),
        .mode_in     (win_mode),
        .cnt_in      (word_vec),
        .clr_overrun (CLR_OVERRUN),
        .m           (dout_bus),
        .overrun     (OVERRUN),
        .frame_cnt   (FRAME_CNT)
    );

endmodule
